// File: rtl/led_frame_loader.sv
// SPI mode-0 pixel loader: synchronizes the pins, assembles MSB-first bytes and
// turns each transaction (address byte + pixel bytes) into frame-buffer writes.
module led_frame_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              mosi_in,
    input  logic              cs_n_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_e;

    // Two synchronizer stages plus one edge-detect stage per control pin
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    logic [1:0] flush_q, flush_d;
    logic       armed_q, armed_d;
    logic       cs_rise_q, cs_rise_d;
    logic       cs_fall_q, cs_fall_d;
    logic       sclk_rise;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              byte_vld_q, byte_vld_d;
    logic              clr_bits;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrote_q, wrote_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;

    // A CS fall only counts once CS has been seen high after reset; otherwise a
    // transaction cut by reset would restart when the idle-high reset value drains.
    always_comb begin
        flush_d   = flush_q;
        if (flush_q != 2'd2) begin
            flush_d = flush_q + 2'd1;
        end
        armed_d   = armed_q | ((flush_q == 2'd2) & cs_s2_q);
        cs_rise_d = cs_s2_q & ~cs_s3_q;
        cs_fall_d = ~cs_s2_q & cs_s3_q & armed_q;
    end

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        byte_vld_d = 1'b0;
        if (clr_bits) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (sclk_rise && (state_q != ST_IDLE)) begin
            shift_d    = {shift_q[DATA_W-2:0], mosi_s2_q};
            cnt_d      = cnt_q + 3'd1;
            byte_vld_d = (cnt_q == 3'd7);
        end
    end

    // Byte completion is handled before the CS rise so a byte finishing in the
    // same cycle is still written and counts toward frame_done.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        wrote_d      = wrote_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        clr_bits     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_q) begin
                    state_d  = ST_ADDR;
                    wrote_d  = 1'b0;
                    clr_bits = 1'b1;
                end
            end
            ST_ADDR: begin
                if (byte_vld_q) begin
                    ptr_d   = shift_q[ADDR_W-1:0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (byte_vld_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = shift_q;
                    ptr_d     = ptr_q + 1'b1;
                    wrote_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && cs_rise_q) begin
            state_d = ST_IDLE;
            if (cnt_q != 3'd0) begin
                err_d = 1'b1;
            end
            if (wrote_d) begin
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q    <= 1'b0;
            sclk_s2_q    <= 1'b0;
            sclk_s3_q    <= 1'b0;
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            cs_s3_q      <= 1'b1;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            flush_q      <= '0;
            armed_q      <= 1'b0;
            cs_rise_q    <= 1'b0;
            cs_fall_q    <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            byte_vld_q   <= 1'b0;
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            wrote_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sclk_s1_q    <= sclk_in;
            sclk_s2_q    <= sclk_s1_q;
            sclk_s3_q    <= sclk_s2_q;
            cs_s1_q      <= cs_n_in;
            cs_s2_q      <= cs_s1_q;
            cs_s3_q      <= cs_s2_q;
            mosi_s1_q    <= mosi_in;
            mosi_s2_q    <= mosi_s1_q;
            flush_q      <= flush_d;
            armed_q      <= armed_d;
            cs_rise_q    <= cs_rise_d;
            cs_fall_q    <= cs_fall_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            byte_vld_q   <= byte_vld_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            wrote_q      <= wrote_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_led_frame_loader.sv
// Bench for led_frame_loader: pin-level SPI driver feeding a transaction-level
// model that schedules every expected output event by clk cycle.
module tb_led_frame_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk_in = 1'b0;
    logic              mosi_in = 1'b0;
    logic              cs_n_in = 1'b1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              busy;
    logic              err;

    led_frame_loader #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk_in    (sclk_in),
        .mosi_in    (mosi_in),
        .cs_n_in    (cs_n_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Expected events keyed by the clk cycle in which they must be visible
    int exp_wr   [int];
    bit exp_fd   [int];
    bit busy_evt [int];
    bit err_evt  [int];
    bit busy_exp = 1'b0;
    bit err_exp  = 1'b0;
    int last_addr = 0;
    int last_data = 0;

    int obs_wr[$];
    int obs_fd = 0;
    bit checking = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    // Transaction state as seen from the pins
    bit m_armed = 1'b1;
    bit t_valid = 1'b0;
    int t_bits  = 0;
    int t_addr  = 0;
    bit t_wrote = 1'b0;
    int cur     = 0;
    int tx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (rst_seen) begin
                busy_exp  = 1'b0;
                err_exp   = 1'b0;
                last_addr = 0;
                last_data = 0;
                chk("rst_wr_en", wr_en, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_wr_data", wr_data, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_busy", busy, 0);
                chk("rst_err", err, 0);
            end else begin
                if (busy_evt.exists(cyc)) busy_exp = busy_evt[cyc];
                if (err_evt.exists(cyc)) err_exp = 1'b1;
                if (exp_wr.exists(cyc)) begin
                    last_addr = exp_wr[cyc] / 256;
                    last_data = exp_wr[cyc] % 256;
                    chk("wr_en", wr_en, 1);
                end else begin
                    chk("wr_en", wr_en, 0);
                end
                chk("wr_addr", wr_addr, last_addr);
                chk("wr_data", wr_data, last_data);
                chk("frame_done", frame_done, exp_fd.exists(cyc));
                chk("busy", busy, busy_exp);
                chk("err", err, err_exp);
                if (wr_en === 1'b1) obs_wr.push_back(int'(wr_addr) * 256 + int'(wr_data));
                if (frame_done === 1'b1) obs_fd++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic void purge(input int r);
        int keys[$];
        foreach (exp_wr[k]) if (k > r) keys.push_back(k);
        foreach (keys[i]) exp_wr.delete(keys[i]);
        keys.delete();
        foreach (exp_fd[k]) if (k > r) keys.push_back(k);
        foreach (keys[i]) exp_fd.delete(keys[i]);
        keys.delete();
        foreach (busy_evt[k]) if (k > r) keys.push_back(k);
        foreach (keys[i]) busy_evt.delete(keys[i]);
        keys.delete();
        foreach (err_evt[k]) if (k > r) keys.push_back(k);
        foreach (keys[i]) err_evt.delete(keys[i]);
    endfunction

    task automatic do_reset(input bit toggle, input bit cs_after);
        tick();
        rst = 1'b1;
        purge(cyc);
        t_valid = 1'b0;
        if (toggle) begin
            sclk_in = ~sclk_in;
            mosi_in = ~mosi_in;
            cs_n_in = ~cs_n_in;
        end
        tick();
        checking = 1'b1;
        if (toggle) begin
            sclk_in = ~sclk_in;
            mosi_in = ~mosi_in;
            cs_n_in = ~cs_n_in;
        end
        tick();
        if (toggle) begin
            sclk_in = 1'b0;
            mosi_in = 1'($urandom_range(0, 1));
        end
        cs_n_in = cs_after;
        rst     = 1'b0;
        m_armed = cs_after;
    endtask

    task automatic cs_low();
        cs_n_in = 1'b0;
        t_valid = m_armed;
        if (t_valid) begin
            busy_evt[cyc + 4] = 1'b1;
            t_bits  = 0;
            t_wrote = 1'b0;
            cur     = 0;
        end
    endtask

    task automatic cs_high_now();
        cs_n_in = 1'b1;
        m_armed = 1'b1;
        if (t_valid) begin
            busy_evt[cyc + 4] = 1'b0;
            if ((t_bits % 8) != 0) err_evt[cyc + 4] = 1'b1;
            if (t_wrote) exp_fd[cyc + 4] = 1'b1;
        end
        t_valid = 1'b0;
    endtask

    // First byte is the start address; byte k>=1 lands at (addr + k - 1) mod depth
    task automatic send_bit(input int b, input bit with_cs);
        int bi;
        mosi_in = b[0];
        idle(4);
        sclk_in = 1'b1;
        if (t_valid) begin
            cur = ((cur << 1) | b) & 255;
            t_bits++;
            if ((t_bits % 8) == 0) begin
                bi = t_bits / 8 - 1;
                if (bi == 0) begin
                    t_addr = cur % DEPTH;
                end else begin
                    exp_wr[cyc + 4] = ((t_addr + bi - 1) % DEPTH) * 256 + cur;
                    t_wrote = 1'b1;
                end
            end
        end
        if (with_cs) cs_high_now();
        idle(4);
        sclk_in = 1'b0;
    endtask

    task automatic run_txn(input int bytes[$], input int extra, input bit coincide, input int rst_at);
        int bits[$];
        foreach (bytes[i]) for (int k = 7; k >= 0; k--) bits.push_back((bytes[i] >> k) & 1);
        repeat (extra) bits.push_back(int'($urandom_range(0, 1)));
        idle(6);
        cs_low();
        foreach (bits[i]) begin
            if (i == rst_at) do_reset(1'b0, 1'b0);
            send_bit(bits[i], coincide && (i == bits.size() - 1));
        end
        if (!(coincide && bits.size() > 0)) begin
            idle(4);
            cs_high_now();
        end
        idle(8);
    endtask

    task automatic expect_obs(input string nm, input int exp_q[$], input int fd);
        chk({nm, "_count"}, obs_wr.size(), exp_q.size());
        foreach (exp_q[i]) chk(nm, (i < obs_wr.size()) ? obs_wr[i] : -1, exp_q[i]);
        chk({nm, "_frame_done"}, obs_fd, fd);
        obs_wr.delete();
        obs_fd = 0;
    endtask

    initial begin
        do_reset(1'b1, 1'b1);
        idle(12);
        expect_obs("after_reset", '{}, 0);

        tx = '{32'h00, 32'h11, 32'h22, 32'h33};
        run_txn(tx, 0, 1'b0, -1);
        expect_obs("basic", '{32'h0011, 32'h0122, 32'h0233}, 1);
        chk("basic_err", err, 0);

        tx = '{32'hFE, 32'hA1, 32'hB2, 32'hC3};
        run_txn(tx, 0, 1'b0, -1);
        expect_obs("wrap", '{32'h3EA1, 32'h3FB2, 32'h00C3}, 1);

        tx = '{32'h05};
        run_txn(tx, 0, 1'b0, -1);
        expect_obs("addr_only", '{}, 0);
        chk("addr_only_err", err, 0);

        tx = '{32'h00, 32'hAA};
        run_txn(tx, 5, 1'b0, -1);
        expect_obs("abort", '{32'h00AA}, 1);
        chk("abort_err", err, 1);

        tx = '{32'h10, 32'h55};
        run_txn(tx, 0, 1'b0, -1);
        expect_obs("after_abort", '{32'h1055}, 1);
        chk("err_sticky", err, 1);

        tx = '{32'h00, 32'hC3};
        run_txn(tx, 0, 1'b0, 12);
        expect_obs("rst_mid", '{}, 0);
        chk("rst_mid_err", err, 0);

        tx = '{32'h20, 32'h77};
        run_txn(tx, 0, 1'b0, -1);
        expect_obs("after_rst_mid", '{32'h2077}, 1);

        tx = '{32'h07, 32'h99};
        run_txn(tx, 0, 1'b1, -1);
        expect_obs("coincide", '{32'h0799}, 1);
        chk("coincide_err", err, 0);

        for (int n = 0; n < 40; n++) begin
            int nb;
            int ex;
            bit co;
            int ra;
            tx.delete();
            nb = $urandom_range(0, 5);
            for (int k = 0; k < nb; k++) tx.push_back(int'($urandom_range(0, 255)));
            ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            co = (ex == 0) && (nb > 0) && ($urandom_range(0, 3) == 0);
            ra = (($urandom_range(0, 9) == 0) && (nb * 8 + ex > 1)) ?
                 int'($urandom_range(1, nb * 8 + ex - 1)) : -1;
            run_txn(tx, ex, co, ra);
            if ($urandom_range(0, 7) == 0) do_reset(1'b1, 1'b1);
        end

        idle(20);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_frame_loader.md
# led_frame_loader

Serial pixel loader that sits directly upstream of the LED matrix driver's frame buffer. It receives SPI mode-0 transactions from off-chip pins routed through `ui_in`, assembles bytes, and issues single-cycle writes into the driver's frame-buffer write port. Each transaction carries a start address followed by any number of pixel bytes. A one-cycle strobe marks the end of every transaction that wrote at least one pixel.

## Interface
- `ADDR_W`, default 6: frame-buffer address width; depth = 2**ADDR_W pixels (64 = 8x8 matrix).
- `DATA_W`, fixed 8: pixel word width.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `sclk_in`, input, 1: SPI clock pin; asynchronous to `clk`.
- `mosi_in`, input, 1: SPI data pin, MSB first; asynchronous.
- `cs_n_in`, input, 1: SPI chip select, active low; asynchronous.
- `wr_en`, output, 1: frame-buffer write strobe, one `clk` wide.
- `wr_addr`, output, ADDR_W: frame-buffer write address; valid while `wr_en` is high.
- `wr_data`, output, 8: pixel data; valid while `wr_en` is high.
- `frame_done`, output, 1: one-cycle pulse at the end of a transaction that wrote at least one pixel.
- `busy`, output, 1: high while a transaction is active (CS asserted, after synchronization).
- `err`, output, 1: sticky flag; set when CS deasserts mid-byte. Cleared only by `rst`.

## Operation
- Input synchronization:
  - `sclk_in`, `mosi_in` and `cs_n_in` each pass through a 2-FF synchronizer.
  - A third register on the synchronized `sclk` and `cs_n` provides edge detection.
  - `mosi` is sampled from its synchronized value on a detected `sclk` rising edge.
- Shift register: 8 bits, MSB first. A 3-bit counter counts edges; the byte is complete on the 8th edge.
- FSM states:
  - IDLE: `cs_n` sync high. Falling edge of `cs_n` → ADDR; clear the bit counter and the `wrote` flag.
  - ADDR: on byte complete, load the pointer with byte[ADDR_W-1:0] (upper bits ignored) → DATA.
  - DATA: on byte complete, pulse `wr_en` with `wr_addr`=pointer and `wr_data`=byte. Then pointer ← pointer+1, wrapping mod 2**ADDR_W (63 → 0), and set `wrote`.
- Rising edge of `cs_n` in ADDR or DATA → IDLE:
  - If the bit counter ≠ 0, discard the partial byte and set `err`.
  - If `wrote`=1, pulse `frame_done` in the cycle the edge is detected.
- `sclk` edges while in IDLE are ignored.
- `busy` = (state ≠ IDLE).
- Reset, applied at any time including mid-transaction:
  - FSM → IDLE; shift register, bit counter, pointer and `wrote` → 0.
  - Synchronizer flops reset to idle levels: `cs_n`=1, `sclk`=0, `mosi`=0.
  - All outputs → 0.
  - A transaction in flight at reset is lost. The loader waits for a fresh `cs_n` falling edge; it does not resume in ADDR.

## Timing
- Pin to edge detect: 3 `clk` cycles (2 sync + 1 edge register).
- `wr_en` is asserted in the cycle after the 8th `sclk` rising edge is detected, i.e. 4 `clk` cycles after the 8th `sclk` pin edge.
- `wr_addr`/`wr_data` are registered and held stable for the `wr_en` cycle. Outside `wr_en` they hold their last value.
- `frame_done` is registered and asserted 4 `clk` cycles after the `cs_n` pin rises.
- Coincident events in the same `clk` cycle:
  - `cs_n` rising together with the 8th `sclk` edge: the byte completes first, so `wr_en` and `frame_done` may assert in the same cycle, and `err` is not set.
  - `cs_n` falling while the FSM is still in ADDR/DATA (no detected rise between): not possible after synchronization; no special handling is required.
- Source constraints: `sclk` high and low each ≥ 4 `clk` periods. `cs_n` high ≥ 4 `clk` periods between transactions. `mosi` stable ≥ 3 `clk` periods before each `sclk` rise.
- No backpressure: the frame buffer accepts one write per cycle unconditionally.

## Test plan
- Reset: hold `rst` 2 cycles with pins toggling → all outputs 0, `busy`=0; after release, no `wr_en` occurs until a `cs_n` falling edge.
- Basic frame: CS low, send 0x00 then 0x11, 0x22, 0x33, CS high → three `wr_en` pulses with (addr, data) = (0,0x11), (1,0x22), (2,0x33); then one `frame_done` pulse; `err`=0.
- Wrap and address masking: send address 0xFE (masks to 62) then 3 bytes → writes at 62, 63, 0.
- Address only: send 0x05, CS high → no `wr_en`, no `frame_done`, `err`=0.
- Abort: send 0x00, 0xAA, then 5 bits, CS high → one write (0,0xAA), `frame_done` pulses, `err`=1 and stays 1 through the next clean transaction until `rst`.
- Reset mid-transaction: assert `rst` after 4 bits of a data byte, release, continue clocking bits with CS still low → no `wr_en` until CS rises and falls again; the next transaction writes normally from its new address.
